// File: rtl/oled_phase_sequencer_if.sv
// Bus bundle between the phase sequencer and its OLED client blocks / pins.
// master = sequencer side, slave = client/pin side.
interface oled_phase_sequencer_if #(
  parameter int NUM_PHASES = 3,
  parameter int IDX_W      = 4
);
  logic                  START;
  logic [NUM_PHASES-1:0] PH_DONE;
  logic [NUM_PHASES-1:0] PH_CS;
  logic [NUM_PHASES-1:0] PH_SDO;
  logic [NUM_PHASES-1:0] PH_SCLK;
  logic [NUM_PHASES-1:0] PH_DC;
  logic [NUM_PHASES-1:0] PH_EN;
  logic                  CS;
  logic                  SDIN;
  logic                  SCLK;
  logic                  DC;
  logic                  BUSY;
  logic [IDX_W-1:0]      PHASE;
  logic                  ERR;

  modport master (
    input  START, PH_DONE, PH_CS, PH_SDO, PH_SCLK, PH_DC,
    output PH_EN, CS, SDIN, SCLK, DC, BUSY, PHASE, ERR
  );

  modport slave (
    output START, PH_DONE, PH_CS, PH_SDO, PH_SCLK, PH_DC,
    input  PH_EN, CS, SDIN, SCLK, DC, BUSY, PHASE, ERR
  );
endinterface

// File: rtl/oled_phase_sequencer.sv
// Runs NUM_PHASES OLED client blocks in order (phase 0 = init) with a one-cycle gap
// between phases; optional per-phase watchdog enabled by macro OLED_SEQ_TIMEOUT_EN.
module oled_phase_sequencer #(
  parameter int NUM_PHASES     = 3,
  parameter int IDX_W          = 4,
  parameter int AUTO_START     = 1,
  parameter int LOOP_START     = 3,
  parameter int RERUN_PHASE    = 1,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input logic                    CLK,
  input logic                    RST,
  oled_phase_sequencer_if.master bus
);

  if (NUM_PHASES < 2 || NUM_PHASES > 16 || (1 << IDX_W) < NUM_PHASES ||
      RERUN_PHASE < 1 || RERUN_PHASE >= NUM_PHASES || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("oled_phase_sequencer: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE
`ifdef OLED_SEQ_TIMEOUT_EN
    , S_ERROR
`endif
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PHASES - 1);
  localparam logic [IDX_W-1:0] LOOP_IDX  = IDX_W'(LOOP_START);
  localparam logic [IDX_W-1:0] RERUN_IDX = IDX_W'(RERUN_PHASE);
  localparam bit               DO_LOOP   = (LOOP_START < NUM_PHASES);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_phase;
  logic [IDX_W-1:0]      w_phase_nxt;
  logic [NUM_PHASES-1:0] w_sel;
  logic                  w_done;

  // One-hot select by shift so an index wider than the phase vector never goes out of range.
  assign w_sel  = NUM_PHASES'(1) << r_phase;
  assign w_done = |(bus.PH_DONE & w_sel);

`ifdef OLED_SEQ_TIMEOUT_EN
  localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_wdog;

  // Held at zero outside RUN, so every entry to RUN starts a fresh count.
  always_ff @(posedge CLK) begin
    if (RST || r_state != S_RUN) r_wdog <= '0;
    else                         r_wdog <= r_wdog + 1'b1;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    case (r_state)
      S_IDLE: begin
        if (AUTO_START != 0 || bus.START) begin
          w_state_nxt = S_RUN;
          w_phase_nxt = '0;
        end
      end
      S_RUN: begin
        if (w_done) begin
          if (r_phase != LAST_IDX) begin
            w_state_nxt = S_GAP;
            w_phase_nxt = r_phase + 1'b1;
          end else if (DO_LOOP) begin
            w_state_nxt = S_GAP;
            w_phase_nxt = LOOP_IDX;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
`ifdef OLED_SEQ_TIMEOUT_EN
        else if (r_wdog == CNT_LIM) begin
          w_state_nxt = S_ERROR;
        end
`endif
      end
      S_GAP: w_state_nxt = S_RUN;
      S_DONE: begin
        if (bus.START) begin
          w_state_nxt = S_GAP;
          w_phase_nxt = RERUN_IDX;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.PH_EN = '0;
    bus.CS    = 1'b1;
    bus.SDIN  = 1'b0;
    bus.SCLK  = 1'b1;
    bus.DC    = 1'b0;
    if (r_state == S_RUN) begin
      bus.PH_EN = w_sel;
      bus.CS    = |(bus.PH_CS   & w_sel);
      bus.SDIN  = |(bus.PH_SDO  & w_sel);
      bus.SCLK  = |(bus.PH_SCLK & w_sel);
      bus.DC    = |(bus.PH_DC   & w_sel);
    end
  end

  assign bus.BUSY  = (r_state == S_RUN) || (r_state == S_GAP);
  assign bus.PHASE = r_phase;

`ifdef OLED_SEQ_TIMEOUT_EN
  assign bus.ERR = (r_state == S_ERROR);
`else
  assign bus.ERR = 1'b0;
`endif

endmodule
